// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_seq                                                   |
// | Function : valid/ready EX-stage ALU, one-cycle ops plus iterative    |
// |            MUL/DIV/REM when the ALU_MULDIV_EN macro is defined       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] aluin1_ex,
   input  logic [XLEN-1:0] aluin2_ex,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            sub_carryout
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] c_OP_AND  = 4'b0000;
   localparam logic [3:0] c_OP_OR   = 4'b0001;
   localparam logic [3:0] c_OP_ADD  = 4'b0010;
   localparam logic [3:0] c_OP_SUB  = 4'b0110;
   localparam logic [3:0] c_OP_XOR  = 4'b1111;
   localparam logic [3:0] c_OP_NOR  = 4'b1100;
   localparam logic [3:0] c_OP_SLL  = 4'b0101;
   localparam logic [3:0] c_OP_SRL  = 4'b0111;
   localparam logic [3:0] c_OP_SRA  = 4'b1000;
   localparam logic [3:0] c_OP_SLT  = 4'b1011;
   localparam logic [3:0] c_OP_SLTU = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   logic [XLEN:0]   w_sub;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_single;
   logic            w_accept;

   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid && in_ready && !flush;

   always_comb begin : p_single
      w_sub    = {1'b0, aluin1_ex} + {1'b0, ~aluin2_ex} + (XLEN+1)'(1);
      w_shamt  = aluin2_ex[SHW-1:0];
      w_single = '0;
      case (alu_control)
         c_OP_AND:  w_single = aluin1_ex & aluin2_ex;
         c_OP_OR:   w_single = aluin1_ex | aluin2_ex;
         c_OP_ADD:  w_single = aluin1_ex + aluin2_ex;
         c_OP_SUB:  w_single = w_sub[XLEN-1:0];
         c_OP_XOR:  w_single = aluin1_ex ^ aluin2_ex;
         c_OP_NOR:  w_single = ~(aluin1_ex | aluin2_ex);
         c_OP_SLL:  w_single = aluin1_ex << w_shamt;
         c_OP_SRL:  w_single = aluin1_ex >> w_shamt;
         c_OP_SRA:  w_single = $signed(aluin1_ex) >>> w_shamt;
         c_OP_SLT:  w_single = XLEN'($signed(aluin1_ex) < $signed(aluin2_ex));
         c_OP_SLTU: w_single = XLEN'(aluin1_ex < aluin2_ex);
         default:   w_single = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam int         CW       = $clog2(XLEN + 1);
   localparam logic [3:0] c_OP_MUL = 4'b1001;
   localparam logic [3:0] c_OP_DIV = 4'b1101;
   localparam logic [3:0] c_OP_REM = 4'b1110;

   // r_x: multiplicand / dividend-then-quotient, r_y: multiplier / divisor
   logic [XLEN-1:0] r_acc, r_x, r_y;
   logic            r_mul, r_div, r_neg_a, r_neg_b, r_b_zero;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] w_abs_a, w_abs_b, w_mul_nx, w_rem_sh, w_rem_nx, w_fix;
   logic            w_is_iter, w_rem_ge;

   assign w_is_iter = (alu_control == c_OP_MUL) || (alu_control == c_OP_DIV) ||
                      (alu_control == c_OP_REM);

   always_comb begin : p_step
      w_abs_a  = aluin1_ex[XLEN-1] ? -aluin1_ex : aluin1_ex;
      w_abs_b  = aluin2_ex[XLEN-1] ? -aluin2_ex : aluin2_ex;
      w_mul_nx = r_acc + (r_y[0] ? r_x : '0);
      // partial remainder stays below |B| <= 2^(XLEN-1), so its MSB is always free
      w_rem_sh = {r_acc[XLEN-2:0], r_x[XLEN-1]};
      w_rem_ge = (w_rem_sh >= r_y);
      w_rem_nx = w_rem_ge ? (w_rem_sh - r_y) : w_rem_sh;
      if (r_mul)
         w_fix = r_acc;
      else if (!r_div)
         w_fix = r_neg_a ? -r_acc : r_acc;
      else if (r_b_zero)
         w_fix = '1;
      else
         w_fix = (r_neg_a ^ r_neg_b) ? -r_x : r_x;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin : p_fsm
      if (!rst_n) begin
         r_state      <= S_IDLE;
         result       <= '0;
         sub_carryout <= 1'b0;
`ifdef ALU_MULDIV_EN
         r_cnt        <= '0;
         r_acc        <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_mul        <= 1'b0;
         r_div        <= 1'b0;
         r_neg_a      <= 1'b0;
         r_neg_b      <= 1'b0;
         r_b_zero     <= 1'b0;
`endif
      end else if (flush) begin
         r_state <= S_IDLE;
`ifdef ALU_MULDIV_EN
         r_cnt   <= '0;
`endif
      end else if (w_accept) begin
         sub_carryout <= w_sub[XLEN];
`ifdef ALU_MULDIV_EN
         if (w_is_iter) begin
            r_state  <= S_BUSY;
            r_cnt    <= CW'(XLEN);
            r_mul    <= (alu_control == c_OP_MUL);
            r_div    <= (alu_control == c_OP_DIV);
            r_neg_a  <= aluin1_ex[XLEN-1];
            r_neg_b  <= aluin2_ex[XLEN-1];
            r_b_zero <= (aluin2_ex == '0);
            r_acc    <= '0;
            r_x      <= (alu_control == c_OP_MUL) ? aluin1_ex : w_abs_a;
            r_y      <= (alu_control == c_OP_MUL) ? aluin2_ex : w_abs_b;
         end else begin
            r_state <= S_DONE;
            result  <= w_single;
         end
`else
         r_state <= S_DONE;
         result  <= w_single;
`endif
      end else begin
         case (r_state)
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_mul) begin
                  r_acc <= w_mul_nx;
                  r_x   <= r_x << 1;
                  r_y   <= r_y >> 1;
               end else begin
                  r_acc <= w_rem_nx;
                  r_x   <= {r_x[XLEN-2:0], w_rem_ge};
               end
               if (r_cnt == CW'(1))
                  r_state <= S_FIX;
            end
            S_FIX: begin
               result  <= w_fix;
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready)
                  r_state <= S_IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                |
// | Function : self-checking bench for alu_seq (vectors, corner          |
// |            sequences and randomized ops vs. reference model)         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_alu_seq;
   localparam int XLEN = 64;
`ifdef ALU_MULDIV_EN
   localparam bit c_MD = 1'b1;
`else
   localparam bit c_MD = 1'b0;
`endif
   localparam logic [63:0] c_MIN = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, sub_carryout;
   logic [3:0]  alu_control = 4'd0;
   logic [63:0] aluin1_ex = '0, aluin2_ex = '0, result;
   int          n_checks = 0, n_errors = 0;

   alu_seq #(.XLEN(XLEN)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_control  (alu_control),
      .aluin1_ex    (aluin1_ex),
      .aluin2_ex    (aluin2_ex),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .sub_carryout (sub_carryout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        c;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   function automatic bit is_iter(input logic [3:0] op);
      return c_MD && (op == 4'b1001 || op == 4'b1101 || op == 4'b1110);
   endfunction

   // Reference behaviour straight from the opcode table, using native arithmetic
   function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      logic signed [63:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b1111: return a ^ b;
         4'b1100: return ~(a | b);
         4'b0101: return a << b[5:0];
         4'b0111: return a >> b[5:0];
         4'b1000: return sa >>> b[5:0];
         4'b1011: return (sa < sb) ? 64'd1 : 64'd0;
         4'b1010: return (a < b) ? 64'd1 : 64'd0;
         4'b1001: return c_MD ? a * b : 64'd0;
         4'b1101: begin
            if (!c_MD) return 64'd0;
            if (b == 64'd0) return '1;
            if (b == '1) return -a;
            return sa / sb;
         end
         4'b1110: begin
            if (!c_MD) return 64'd0;
            if (b == 64'd0) return a;
            if (b == '1) return 64'd0;
            return sa % sb;
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return c_MIN;
         3:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic idle();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Offer one op with out_ready high, measure latency, then compare the result
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input logic exp_c, input string nm);
      int   lat, exp_lat, w;
      logic busy_bad;
      exp_lat     = is_iter(op) ? XLEN + 1 : 1;
      out_ready   = 1'b1;
      alu_control = op;
      aluin1_ex   = a;
      aluin2_ex   = b;
      in_valid    = 1'b1;
      w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 200) check({nm, "_accept"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      alu_control = 4'($urandom);
      aluin1_ex   = {$urandom, $urandom};
      aluin2_ex   = {$urandom, $urandom};
      lat      = 1;
      busy_bad = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_bad = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
      check({nm, "_res"}, result, exp_res);
      check({nm, "_carry"}, 64'(sub_carryout), 64'(exp_c));
      if (exp_lat > 1) check({nm, "_busy_ready"}, 64'(busy_bad), 64'd0);
   endtask

   initial begin : p_watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin : p_main
      vec_t        vecs [20];
      logic        bad;
      logic [3:0]  op;
      logic [63:0] a, b;

      vecs[0]  = '{4'b0010, '1, 64'd1, 64'd0, 1'b1};
      vecs[1]  = '{4'b0110, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[2]  = '{4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b1};
      vecs[3]  = '{4'b0001, 64'hF000, 64'h000F, 64'hF00F, 1'b1};
      vecs[4]  = '{4'b1111, 64'hFF, 64'h0F, 64'hF0, 1'b1};
      vecs[5]  = '{4'b1100, 64'd0, 64'd0, '1, 1'b1};
      vecs[6]  = '{4'b0101, 64'd1, 64'h143, 64'd8, 1'b0};
      vecs[7]  = '{4'b0111, c_MIN, 64'd63, 64'd1, 1'b1};
      vecs[8]  = '{4'b1000, c_MIN, 64'd4, 64'hF800_0000_0000_0000, 1'b1};
      vecs[9]  = '{4'b1011, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0};
      vecs[10] = '{4'b1010, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0};
      vecs[11] = '{4'b0011, 64'd7, 64'd3, 64'd0, 1'b1};
      vecs[12] = '{4'b0100, 64'd7, 64'd3, 64'd0, 1'b1};
      vecs[13] = '{4'b1001, 64'hFFFF_FFFF, 64'd3, c_MD ? 64'h2_FFFF_FFFD : 64'd0, 1'b1};
      vecs[14] = '{4'b1101, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                   c_MD ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0, 1'b1};
      vecs[15] = '{4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, c_MD ? '1 : 64'd0, 1'b1};
      vecs[16] = '{4'b1101, 64'd5, 64'd0, c_MD ? '1 : 64'd0, 1'b1};
      vecs[17] = '{4'b1110, 64'd5, 64'd0, c_MD ? 64'd5 : 64'd0, 1'b1};
      vecs[18] = '{4'b1101, c_MIN, '1, c_MD ? c_MIN : 64'd0, 1'b0};
      vecs[19] = '{4'b1110, c_MIN, '1, 64'd0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_carry", 64'(sub_carryout), 64'd0);
      rst_n = 1'b1;
      idle();

      for (int i = 0; i < 20; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c,
                $sformatf("vec%0d", i));

      // back-to-back single-cycle ops, one per clock
      idle();
      alu_control = 4'b1011; aluin1_ex = '1; aluin2_ex = 64'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b_slt_valid", 64'(out_valid), 64'd1);
      check("b2b_slt", result, 64'd1);
      alu_control = 4'b1010;
      @(posedge clk); #1;
      check("b2b_sltu_valid", 64'(out_valid), 64'd1);
      check("b2b_sltu", result, 64'd0);
      alu_control = 4'b1000; aluin1_ex = c_MIN; aluin2_ex = 64'd63;
      @(posedge clk); #1;
      check("b2b_sra_valid", 64'(out_valid), 64'd1);
      check("b2b_sra", result, '1);
      in_valid = 1'b0;

      // consumer stall: result held, new offers refused until out_ready returns
      idle();
      out_ready = 1'b0;
      alu_control = 4'b0010; aluin1_ex = 64'd10; aluin2_ex = 64'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      alu_control = 4'b0110; aluin1_ex = 64'd100; aluin2_ex = 64'd1;
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (result !== 64'd30 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
             sub_carryout !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      check("stall_hold", 64'(bad), 64'd0);
      check("stall_result", result, 64'd30);
      out_ready = 1'b1;
      #1;
      check("stall_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_next_valid", 64'(out_valid), 64'd1);
      check("stall_next_res", result, 64'd99);
      check("stall_next_carry", 64'(sub_carryout), 64'd1);

      // flush twenty cycles into a divide, with a competing offer in that cycle
      idle();
      out_ready = 1'b0;
      alu_control = 4'b1101; aluin1_ex = 64'd100; aluin2_ex = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      flush = 1'b1; in_valid = 1'b1; alu_control = 4'b0010;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      bad = 1'b0;
      for (int k = 0; k < 70; k++) begin
         if (out_valid) bad = 1'b1;
         @(posedge clk); #1;
      end
      check("flush_no_result", 64'(bad), 64'd0);

      // asynchronous reset in the middle of a divide
      idle();
      alu_control = 4'b1101; aluin1_ex = 64'd5; aluin2_ex = 64'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_result", result, 64'd0);
      check("arst_carry", 64'(sub_carryout), 64'd0);
      #1;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 70; k++) begin
         if (out_valid) bad = 1'b1;
         @(posedge clk); #1;
      end
      check("arst_no_result", 64'(bad), 64'd0);

      idle();
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom);
         a  = pick();
         b  = pick();
         run_op(op, a, b, model_res(op, a, b), (a >= b), $sformatf("rnd%0d_op%0h", i, op));
      end

      idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked execution unit replacing the purely combinational 64-bit ALU in the EX stage. It executes the existing single-cycle logic/arith/shift/compare opcodes with one registered cycle of latency. It adds iterative multi-cycle MUL, DIV and REM behind the same valid/ready interface, so the pipeline can stall on long operations.

## Interface
- XLEN, 64, operand/result width; power of two, 8..128
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept this cycle
- alu_control  input  4  opcode
- aluin1_ex  input  XLEN  operand A
- aluin2_ex  input  XLEN  operand B
- flush  input  1  synchronous abort of in-flight/held operation
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- sub_carryout  output  1  registered carry of A + ~B + 1 (1 when A >= B unsigned)

## Operation
- Opcodes, latency 1: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 XOR, 1100 NOR, 0101 SLL, 0111 SRL, 1000 SRA, 1011 SLT (signed), 1010 SLTU (unsigned), any other value gives result 0.
- Shifts use aluin2_ex[SHW-1:0] only. ADD and SUB wrap modulo 2^XLEN.
- Opcodes, iterative: 1001 MUL (low XLEN bits of A*B), 1101 DIV (signed quotient, truncating toward zero), 1110 REM (signed remainder, sign follows A).
- MUL: shift-add, one multiplier bit per cycle.
- DIV/REM: restoring division on |A|, |B|, one quotient bit per cycle, then a sign fix-up cycle.
- DIV/REM special cases:
  - B == 0 gives DIV all-ones and REM = A.
  - A == most-negative with B == all-ones gives DIV = A and REM = 0.
  - Both cases still take full iterative latency.
- sub_carryout is computed from the accepted operands for every opcode.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid. Single-cycle opcode goes to DONE. Iterative opcode goes to BUSY with counter=XLEN.
  - BUSY: in_ready=0. One step per cycle. When counter reaches 0, go to FIX.
  - FIX: apply signs and special cases, then go to DONE.
  - DONE: out_valid=1. If out_ready, release result. If in_valid is also high, accept the new op in the same edge; otherwise go to IDLE. in_ready = out_ready.
- Operands and opcode are captured at acceptance. Later input changes are ignored.
- flush overrides everything: return to IDLE, out_valid=0, no result delivered, and any in_valid in that cycle is not accepted.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, in_ready=1, out_valid=0, result=0, sub_carryout=0, counter=0.
- Single-cycle op accepted at edge N: out_valid=1 after edge N.
- Iterative op accepted at edge N: out_valid=1 after edge N+XLEN+1 (XLEN steps plus FIX).
- result and sub_carryout stay stable while out_valid=1 and out_ready=0.
- Throughput with out_ready held high: one single-cycle op per clock. An iterative op occupies the unit for XLEN+2 cycles.
- rst_n asserted mid-BUSY clears immediately. No partial result appears.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIV/REM are implemented as above, along with BUSY, FIX and the counter.
- ALU_MULDIV_EN undefined:
  - Opcodes 1001/1101/1110 behave as unknown opcodes: result 0, latency 1.
  - BUSY and FIX are unreachable and the multiply/divide datapath is not synthesised.

## Test plan
- Reset, then ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> out_valid one cycle later, result 0, sub_carryout 1.
- Back-to-back SLT(-1,1), SLTU(-1,1), SRA(0x8000_0000_0000_0000, 63), one op per clock -> results 1, 0, all-ones on consecutive cycles.
- MUL 0xFFFF_FFFF × 3 -> result 0x2_FFFF_FFFD exactly 65 cycles after accept, in_ready=0 throughout BUSY/FIX.
- DIV -7/2 and REM -7/2 -> -3 and -1. DIV 5/0 -> all-ones. REM 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0.
- out_ready held 0 for 10 cycles after a result -> result stable, in_ready 0, in_valid ignored. Release out_ready with in_valid high -> new op accepted on the same edge.
- flush at BUSY cycle 20 of a DIV -> IDLE next cycle, out_valid never asserts. Repeat with rst_n pulsed mid-BUSY -> immediate IDLE, all outputs 0.
